rc4_prga_fsm: RTL and testbench

Keystream-generation and decrypt stage that runs directly after the key-schedule swap FSM has finished permuting S-memory. It walks the 256-byte S RAM with the RC4 PRGA (i/j update, swap, f = S[S[i]+S[j]]) and XORs each keystream byte with one byte of the encrypted-message ROM. Each plaintext byte is written to the decrypted-message RAM and checked for being a lowercase letter or a space. The done/key_valid result feeds the key-search controller.

---
 rtl/rc4_pkg.sv | 32 +++
 rtl/rc4_prga_fsm_if.sv | 37 +++
 rtl/rc4_char_check.sv | 20 ++
 rtl/rc4_prga_fsm.sv | 170 +++++++++++++++++
 tb/tb_rc4_prga_fsm.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_pkg.sv
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared types and constants for the RC4 keystream/decrypt stage
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rc4_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INC_I   = 4'd1,
        WAIT_SI = 4'd2,
        GET_SI  = 4'd3,
        WAIT_SJ = 4'd4,
        GET_SJ  = 4'd5,
        WR_SJ   = 4'd6,
        SET_F   = 4'd7,
        WAIT_F  = 4'd8,
        GET_F   = 4'd9,
        NEXT_K  = 4'd10,
        DONE    = 4'd11
    } state_t;

    localparam int         S_DEPTH    = 256;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

endpackage

`default_nettype wire

// File: rtl/rc4_prga_fsm_if.sv
// ============================================================================
//  Module      : rc4_prga_fsm_if
//  Description : Control and memory-port bundle of the RC4 PRGA/decrypt stage
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rc4_prga_fsm_if #(
    parameter int K_W = 5
);
    logic           start;
    logic           done;
    logic           key_valid;
    logic [7:0]     s_q;
    logic [7:0]     s_addr;
    logic [7:0]     s_data;
    logic           s_wren;
    logic [7:0]     rom_q;
    logic [K_W-1:0] rom_addr;
    logic [K_W-1:0] d_addr;
    logic [7:0]     d_data;
    logic           d_wren;

    modport master (
        input  start, s_q, rom_q,
        output done, key_valid, s_addr, s_data, s_wren,
               rom_addr, d_addr, d_data, d_wren
    );

    modport slave (
        output start, s_q, rom_q,
        input  done, key_valid, s_addr, s_data, s_wren,
               rom_addr, d_addr, d_data, d_wren
    );
endinterface

`default_nettype wire

// File: rtl/rc4_char_check.sv
// ============================================================================
//  Module      : rc4_char_check
//  Description : Plaintext filter - passes lowercase ASCII letters and space
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_char_check
    import rc4_pkg::*;
(
    input  wire logic [7:0] i_char,
    output logic            o_pass
);

    assign o_pass = ((i_char >= CHAR_LO) && (i_char <= CHAR_HI)) ||
                    (i_char == CHAR_SPACE);

endmodule

`default_nettype wire

// File: rtl/rc4_prga_fsm.sv
// ============================================================================
//  Module      : rc4_prga_fsm
//  Description : RC4 PRGA over a 256-byte S RAM, XOR-decrypts the message ROM
//                into the D RAM and flags whether all bytes look like text
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_prga_fsm
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int K_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
)(
    input  wire logic      clk,
    input  wire logic      reset,
    rc4_prga_fsm_if.master bus
);

    localparam logic [K_W-1:0] c_k_last = K_W'(MSG_LEN - 1);

    state_t         r_state;
    state_t         w_state_nxt;

    logic [7:0]     r_i;
    logic [7:0]     r_j;
    logic [7:0]     r_si;
    logic [7:0]     r_sj;
    logic [K_W-1:0] r_k;

    logic [7:0]     r_s_addr;
    logic [7:0]     r_s_data;
    logic           r_s_wren;
    logic [K_W-1:0] r_rom_addr;
    logic [K_W-1:0] r_d_addr;
    logic [7:0]     r_d_data;
    logic           r_d_wren;
    logic           r_done;
    logic           r_key_valid;

    logic [7:0]     w_plain;
    logic           w_pass;

    assign w_plain = bus.s_q ^ bus.rom_q;

    rc4_char_check u_char_check (
        .i_char (w_plain),
        .o_pass (w_pass)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = INC_I;
            INC_I:   w_state_nxt = WAIT_SI;
            WAIT_SI: w_state_nxt = GET_SI;
            GET_SI:  w_state_nxt = WAIT_SJ;
            WAIT_SJ: w_state_nxt = GET_SJ;
            GET_SJ:  w_state_nxt = WR_SJ;
            WR_SJ:   w_state_nxt = SET_F;
            SET_F:   w_state_nxt = WAIT_F;
            WAIT_F:  w_state_nxt = GET_F;
            GET_F:   w_state_nxt = NEXT_K;
            // key_valid only ever drops on a failed byte, so it doubles as the abort flag
            NEXT_K:  w_state_nxt = (!r_key_valid || (r_k == c_k_last)) ? DONE : INC_I;
            DONE:    if (!bus.start) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i         <= '0;
            r_j         <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_k         <= '0;
            r_s_addr    <= '0;
            r_s_data    <= '0;
            r_s_wren    <= 1'b0;
            r_rom_addr  <= '0;
            r_d_addr    <= '0;
            r_d_data    <= '0;
            r_d_wren    <= 1'b0;
            r_done      <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            // done lags the DONE state by one register stage
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    r_s_wren <= 1'b0;
                    r_d_wren <= 1'b0;
                    if (bus.start) begin
                        r_i         <= '0;
                        r_j         <= '0;
                        r_k         <= '0;
                        r_rom_addr  <= '0;
                        r_key_valid <= 1'b1;
                    end
                end
                INC_I: begin
                    r_i      <= r_i + 8'd1;
                    r_s_addr <= r_i + 8'd1;
                end
                GET_SI: begin
                    r_si     <= bus.s_q;
                    r_j      <= r_j + bus.s_q;
                    r_s_addr <= r_j + bus.s_q;
                end
                GET_SJ: begin
                    r_sj     <= bus.s_q;
                    r_s_addr <= r_i;
                    r_s_data <= bus.s_q;
                    r_s_wren <= 1'b1;
                end
                WR_SJ: begin
                    r_s_addr <= r_j;
                    r_s_data <= r_si;
                end
                SET_F: begin
                    r_s_wren <= 1'b0;
                    r_s_addr <= r_si + r_sj;
                end
                GET_F: begin
                    r_d_addr <= r_k;
                    r_d_data <= w_plain;
                    r_d_wren <= 1'b1;
                    if (!w_pass) r_key_valid <= 1'b0;
                end
                NEXT_K: begin
                    r_d_wren <= 1'b0;
                    if (r_key_valid && (r_k != c_k_last)) begin
                        r_k        <= r_k + K_W'(1);
                        r_rom_addr <= r_k + K_W'(1);
                    end
                end
                DONE: begin
                    r_s_wren <= 1'b0;
                    r_d_wren <= 1'b0;
                end
                default: begin
                    r_s_wren <= 1'b0;
                    r_d_wren <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_addr    = r_s_addr;
    assign bus.s_data    = r_s_data;
    assign bus.s_wren    = r_s_wren;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.d_addr    = r_d_addr;
    assign bus.d_data    = r_d_data;
    assign bus.d_wren    = r_d_wren;
    assign bus.done      = r_done;
    assign bus.key_valid = r_key_valid;

endmodule

`default_nettype wire

// File: tb/tb_rc4_prga_fsm.sv
// ============================================================================
//  Module      : tb_rc4_prga_fsm
//  Description : Scoreboard bench for rc4_prga_fsm (2-byte and 260-byte builds)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rc4_prga_fsm;
    import rc4_pkg::*;

    localparam int MSG_A = 2;
    localparam int KW_A  = 1;
    localparam int MSG_B = 260;
    localparam int KW_B  = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic s_init = 1'b0;
    logic sel = 1'b0;

    rc4_prga_fsm_if #(.K_W(KW_A)) bus_a ();
    rc4_prga_fsm_if #(.K_W(KW_B)) bus_b ();

    rc4_prga_fsm #(.MSG_LEN(MSG_A), .K_W(KW_A)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    rc4_prga_fsm #(.MSG_LEN(MSG_B), .K_W(KW_B)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

    logic [7:0] s_mem_a [256];
    logic [7:0] rom_a   [MSG_A];
    logic [7:0] d_mem_a [MSG_A];
    logic [7:0] s_mem_b [256];
    logic [7:0] rom_b   [MSG_B];
    logic [7:0] d_mem_b [MSG_B];

    // memories with registered inputs: q reflects the address presented one edge earlier
    always @(posedge clk) begin
        if (s_init) for (int x = 0; x < 256; x++) s_mem_a[x] <= 8'(x);
        else if (bus_a.s_wren) s_mem_a[bus_a.s_addr] <= bus_a.s_data;
        bus_a.s_q   <= s_mem_a[bus_a.s_addr];
        bus_a.rom_q <= rom_a[bus_a.rom_addr];
        if (bus_a.d_wren) d_mem_a[bus_a.d_addr] <= bus_a.d_data;
    end

    always @(posedge clk) begin
        if (s_init) for (int x = 0; x < 256; x++) s_mem_b[x] <= 8'(x);
        else if (bus_b.s_wren) s_mem_b[bus_b.s_addr] <= bus_b.s_data;
        bus_b.s_q   <= s_mem_b[bus_b.s_addr];
        bus_b.rom_q <= (32'(bus_b.rom_addr) < MSG_B) ? rom_b[bus_b.rom_addr] : 8'h00;
        if (bus_b.d_wren) d_mem_b[bus_b.d_addr] <= bus_b.d_data;
    end

    logic        m_done, m_kv, m_d_wren;
    logic [31:0] m_d_addr;
    logic [7:0]  m_d_data;
    assign m_done   = sel ? bus_b.done      : bus_a.done;
    assign m_kv     = sel ? bus_b.key_valid : bus_a.key_valid;
    assign m_d_wren = sel ? bus_b.d_wren    : bus_a.d_wren;
    assign m_d_addr = sel ? 32'(bus_b.d_addr) : 32'(bus_a.d_addr);
    assign m_d_data = sel ? bus_b.d_data    : bus_a.d_data;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } sb_t;

    sb_t        sb_q [$];
    logic [7:0] ks_q [$];
    logic       exp_kv;
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit is_text(input logic [7:0] c);
        return (c inside {[8'h61:8'h7A], 8'h20});
    endfunction

    // reference RC4 PRGA starting from the selected S memory's current contents
    task automatic model_ks(input int n);
        logic [7:0] s [256];
        logic [7:0] i, j, t, f;
        for (int x = 0; x < 256; x++) s[x] = sel ? s_mem_b[x] : s_mem_a[x];
        i = 8'd0;
        j = 8'd0;
        ks_q.delete();
        repeat (n) begin
            i    = i + 8'd1;
            j    = j + s[i];
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
            f    = s[i] + s[j];
            ks_q.push_back(s[f]);
        end
    endtask

    task automatic push_expected(input int n);
        logic [7:0] p;
        sb_t        e;
        model_ks(n);
        exp_kv = 1'b1;
        for (int k = 0; k < n; k++) begin
            p      = ks_q[k] ^ (sel ? rom_b[k] : rom_a[k]);
            e.addr = k;
            e.data = p;
            sb_q.push_back(e);
            if (!is_text(p)) begin
                exp_kv = 1'b0;
                break;
            end
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) bus_b.start = v;
        else     bus_a.start = v;
    endtask

    task automatic pulse_s_init();
        @(negedge clk) s_init = 1'b1;
        @(negedge clk) s_init = 1'b0;
        @(negedge clk);
    endtask

    // one full run: scoreboard every D write, then check latency, hold-in-DONE and release
    task automatic run(input string tag);
        int  cyc, pulses, exp_n;
        bit  seen, bad;
        sb_t e;
        exp_n = sb_q.size();
        @(negedge clk) set_start(1'b1);
        @(posedge clk);
        cyc    = 0;
        pulses = 0;
        seen   = 0;
        @(negedge clk);
        chk({tag, "_kv_init"}, 32'(m_kv), 32'd1);
        while (cyc < 3000) begin
            if (m_d_wren) begin
                pulses++;
                if (sb_q.size() == 0) begin
                    chk({tag, "_extra_wr"}, m_d_addr, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk({tag, "_d_addr"}, m_d_addr, 32'(e.addr));
                    chk({tag, "_d_data"}, 32'(m_d_data), 32'(e.data));
                end
            end
            if (m_done) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(10 * exp_n + 1));
        chk({tag, "_pulses"}, 32'(pulses), 32'(exp_n));
        chk({tag, "_key_valid"}, 32'(m_kv), 32'(exp_kv));
        chk({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (!m_done || m_d_wren) bad = 1;
        end
        chk({tag, "_hold_done"}, 32'(bad), 32'd0);
        set_start(1'b0);
        repeat (2) @(negedge clk);
        chk({tag, "_done_drop"}, 32'(m_done), 32'd0);
    endtask

    localparam string ALPHA = "abcdefghijklmnopqrstuvwxyz ";
    logic [7:0] plain  [MSG_B];
    logic [7:0] bnd_t  [6] = '{8'h20, 8'h7B, 8'h60, 8'h61, 8'h7A, 8'h1F};
    logic       bnd_ok [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    sb_t        e_full;

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        for (int x = 0; x < MSG_B; x++) rom_b[x] = 8'h00;
        #1 rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs_a", 32'(|{bus_a.s_addr, bus_a.s_data, bus_a.s_wren, bus_a.rom_addr,
                                 bus_a.d_addr, bus_a.d_data, bus_a.d_wren, bus_a.done,
                                 bus_a.key_valid}), 32'd0);
        chk("rst_state_a", 32'(dut_a.r_state), 32'(IDLE));
        rst_a = 1'b1;
        rst_b = 1'b1;
        pulse_s_init();

        // identity S: byte 0 exercises i==j, byte 1 swaps S[2]/S[3]
        sel = 1'b0;
        rom_a[0] = 8'h63;
        rom_a[1] = 8'h67;
        push_expected(MSG_A);
        run("a_basic");
        chk("a_d0", 32'(d_mem_a[0]), 32'h61);
        chk("a_d1", 32'(d_mem_a[1]), 32'h62);
        chk("a_s2", 32'(s_mem_a[2]), 32'h03);
        chk("a_s3", 32'(s_mem_a[3]), 32'h02);

        // permuted S left from the previous run: fresh i/j, first byte fails
        push_expected(MSG_A);
        run("a_rerun_perm");
        chk("a_rerun_kv0", 32'(bus_a.key_valid), 32'd0);

        pulse_s_init();
        push_expected(MSG_A);
        run("a_restart_kv1");

        sel = 1'b1;
        pulse_s_init();
        rom_b[0] = 8'h63;
        rom_b[1] = 8'h00;
        push_expected(MSG_B);
        run("b_abort");
        chk("b_abort_d1", 32'(d_mem_b[1]), 32'h05);
        chk("b_abort_k", 32'(bus_b.rom_addr), 32'd1);

        for (int b = 0; b < 6; b++) begin
            pulse_s_init();
            rom_b[0] = bnd_t[b] ^ 8'h02;
            rom_b[1] = 8'h00;
            push_expected(MSG_B);
            run($sformatf("bnd_%02h", bnd_t[b]));
            chk($sformatf("bnd_%02h_d0", bnd_t[b]), 32'(d_mem_b[0]), 32'(bnd_t[b]));
            chk($sformatf("bnd_%02h_k", bnd_t[b]), 32'(bus_b.rom_addr), 32'(bnd_ok[b]));
        end

        // full-length message: ROM = plaintext XOR reference keystream
        pulse_s_init();
        model_ks(MSG_B);
        for (int k = 0; k < MSG_B; k++) begin
            plain[k] = ALPHA[$urandom_range(0, 26)];
            rom_b[k] = plain[k] ^ ks_q[k];
        end

        @(negedge clk) bus_b.start = 1'b1;
        @(posedge clk);
        repeat (55) @(posedge clk);
        #2;
        chk("mid_wren_pre", 32'(bus_b.s_wren), 32'd1);
        rst_b = 1'b0;
        #1;
        chk("mid_rst_outs", 32'(|{bus_b.s_addr, bus_b.s_data, bus_b.s_wren, bus_b.rom_addr,
                                   bus_b.d_addr, bus_b.d_data, bus_b.d_wren, bus_b.done,
                                   bus_b.key_valid}), 32'd0);
        chk("mid_rst_state", 32'(dut_b.r_state), 32'(IDLE));
        @(negedge clk) bus_b.start = 1'b0;
        @(negedge clk) rst_b = 1'b1;

        pulse_s_init();
        for (int k = 0; k < MSG_B; k++) begin
            e_full.addr = k;
            e_full.data = plain[k];
            sb_q.push_back(e_full);
        end
        exp_kv = 1'b1;
        run("b_full260");
        chk("b_full_last", 32'(d_mem_b[MSG_B-1]), 32'(plain[MSG_B-1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
